// File: rtl/sata_link_supervisor.sv
// Link-level supervisor for SATA bring-up: starts OOB, times out and retries
// failed attempts with backoff, debounces phy_ready loss and serves COMRESET.
module sata_link_supervisor #(
  parameter int TMR_W       = 20,
  parameter int OOB_TIMEOUT = 750000,
  parameter int BACKOFF     = 7500,
  parameter int MAX_RETRIES = 4,
  parameter int RETRY_W     = 3,
  parameter int DEBOUNCE    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               link_en,
  input  logic               comreset_req,
  input  logic               phy_ready,
  input  logic               oob_busy,
  input  logic               oob_error,
  output logic               oob_start,
  output logic               comreset_ack,
  output logic               link_up,
  output logic               link_failed,
  output logic [2:0]         state_out,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [15:0]        loss_cnt
);

  typedef enum logic [2:0] {
    S_DISABLED = 3'd0,
    S_START    = 3'd1,
    S_WAIT_OOB = 3'd2,
    S_LINK_UP  = 3'd3,
    S_DEBOUNCE = 3'd4,
    S_BACKOFF  = 3'd5,
    S_FAILED   = 3'd6
  } state_e;

  localparam logic [TMR_W-1:0]   OOB_LAST = TMR_W'(OOB_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   BO_LAST  = TMR_W'(BACKOFF - 1);
  localparam logic [TMR_W-1:0]   DEB_LAST = TMR_W'(DEBOUNCE - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [15:0]        loss_q, loss_d;
  logic               oob_start_q, oob_start_d;
  logic               ack_q, ack_d;
  logic               link_up_q, link_failed_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_DISABLED;
      timer_q       <= '0;
      retry_q       <= '0;
      loss_q        <= 16'd0;
      oob_start_q   <= 1'b0;
      ack_q         <= 1'b0;
      link_up_q     <= 1'b0;
      link_failed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      loss_q        <= loss_d;
      oob_start_q   <= oob_start_d;
      ack_q         <= ack_d;
      link_up_q     <= (state_d == S_LINK_UP) || (state_d == S_DEBOUNCE);
      link_failed_q <= (state_d == S_FAILED);
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    loss_d      = loss_q;
    oob_start_d = 1'b0;
    ack_d       = 1'b0;
    if (!link_en) begin
      state_d = S_DISABLED;
      timer_d = '0;
      retry_d = '0;
    end else if (comreset_req && (state_q != S_DISABLED)) begin
      state_d = S_START;
      timer_d = '0;
      retry_d = '0;
      ack_d   = 1'b1;
    end else begin
      case (state_q)
        S_DISABLED: begin
          state_d = S_START;
        end
        S_START: begin
          if (!oob_busy) begin
            oob_start_d = 1'b1;
            timer_d     = '0;
            state_d     = S_WAIT_OOB;
          end else begin
            state_d = S_START;
          end
        end
        S_WAIT_OOB: begin
          if (phy_ready) begin
            state_d = S_LINK_UP;
            retry_d = '0;
          end else if (oob_error || (timer_q == OOB_LAST)) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAILED;
            end else begin
              retry_d = retry_q + RETRY_W'(1);
              timer_d = '0;
              state_d = S_BACKOFF;
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_BACKOFF: begin
          if (timer_q == BO_LAST) begin
            state_d = S_START;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_LINK_UP: begin
          // The LINK_UP cycle that saw the drop is the first low cycle of the run.
          if (!phy_ready) begin
            state_d = S_DEBOUNCE;
            timer_d = TMR_W'(1);
          end else begin
            state_d = S_LINK_UP;
          end
        end
        S_DEBOUNCE: begin
          if (phy_ready) begin
            state_d = S_LINK_UP;
          end else if (timer_q == DEB_LAST) begin
            if (loss_q != 16'hFFFF) begin
              loss_d = loss_q + 16'd1;
            end else begin
              loss_d = loss_q;
            end
            retry_d = '0;
            timer_d = '0;
            state_d = S_START;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_FAILED: begin
          state_d = S_FAILED;
        end
        default: begin
          state_d = S_DISABLED;
          timer_d = '0;
        end
      endcase
    end
  end

  assign oob_start    = oob_start_q;
  assign comreset_ack = ack_q;
  assign link_up      = link_up_q;
  assign link_failed  = link_failed_q;
  assign state_out    = state_q;
  assign retry_cnt    = retry_q;
  assign loss_cnt     = loss_q;

endmodule

// File: tb/tb_sata_link_supervisor.sv
// Self-checking bench for sata_link_supervisor: vector table, corner-case
// sequences and randomized traffic against an event-level reference model.
module tb_sata_link_supervisor;

  localparam int OOB_TO = 50;
  localparam int BO     = 10;
  localparam int MAXR   = 2;
  localparam int DEB    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0, link_en = 1'b0, comreset_req = 1'b0;
  logic        phy_ready = 1'b0, oob_busy = 1'b0, oob_error = 1'b0;
  logic        oob_start, comreset_ack, link_up, link_failed;
  logic [2:0]  state_out;
  logic [2:0]  retry_cnt;
  logic [15:0] loss_cnt;

  sata_link_supervisor #(
    .TMR_W(20), .OOB_TIMEOUT(OOB_TO), .BACKOFF(BO),
    .MAX_RETRIES(MAXR), .RETRY_W(3), .DEBOUNCE(DEB)
  ) dut (
    .clk(clk), .rst(rst), .link_en(link_en), .comreset_req(comreset_req),
    .phy_ready(phy_ready), .oob_busy(oob_busy), .oob_error(oob_error),
    .oob_start(oob_start), .comreset_ack(comreset_ack), .link_up(link_up),
    .link_failed(link_failed), .state_out(state_out), .retry_cnt(retry_cnt),
    .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase entry times and run lengths rather than a timer.
  int  ms = 0, retries = 0, losses = 0, low_run = 0, since = 0, tick_n = 0;
  bit  e_start = 1'b0, e_ack = 1'b0;

  task automatic model_step();
    e_start = 1'b0;
    e_ack   = 1'b0;
    if (!rst) begin
      ms = 0; retries = 0; losses = 0; low_run = 0;
    end else if (!link_en) begin
      ms = 0; retries = 0;
    end else if (comreset_req && ms != 0) begin
      ms = 1; retries = 0; e_ack = 1'b1;
    end else begin
      case (ms)
        0: ms = 1;
        1: if (!oob_busy) begin e_start = 1'b1; ms = 2; since = tick_n + 1; end
        2: begin
          if (phy_ready) begin
            ms = 3; retries = 0; low_run = 0;
          end else if (oob_error || (tick_n - since) == OOB_TO - 1) begin
            if (retries == MAXR) ms = 6;
            else begin retries++; ms = 5; since = tick_n + 1; end
          end
        end
        5: if ((tick_n - since) == BO - 1) ms = 1;
        3, 4: begin
          low_run = phy_ready ? 0 : low_run + 1;
          if (ms == 3 && !phy_ready) ms = 4;
          else if (ms == 4 && phy_ready) ms = 3;
          else if (ms == 4 && low_run == DEB) begin
            if (losses < 65535) losses++;
            retries = 0;
            ms = 1;
          end
        end
        default: ;
      endcase
    end
    tick_n++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, tick_n);
    end
  endtask

  task automatic tick();
    logic [25:0] act, exp;
    model_step();
    @(posedge clk);
    #1;
    act = {state_out, oob_start, comreset_ack, link_up, link_failed, retry_cnt, loss_cnt};
    exp = {3'(ms), e_start, e_ack, (ms == 3 || ms == 4), (ms == 6), 3'(retries), 16'(losses)};
    chk("model", {6'd0, act}, {6'd0, exp});
  endtask

  typedef struct {
    logic [5:0] in;     // {rst, link_en, comreset_req, phy_ready, oob_busy, oob_error}
    logic [2:0] st;
    logic [3:0] flags;  // {oob_start, comreset_ack, link_up, link_failed}
    logic [2:0] retry;
  } vec_t;

  vec_t tbl [17];
  int   pulses [$];
  bit   bad;

  initial begin
    tbl[0]  = '{6'b000000, 3'd0, 4'b0000, 3'd0};
    tbl[1]  = '{6'b100000, 3'd0, 4'b0000, 3'd0};
    tbl[2]  = '{6'b110010, 3'd1, 4'b0000, 3'd0};
    tbl[3]  = '{6'b110010, 3'd1, 4'b0000, 3'd0};
    tbl[4]  = '{6'b110000, 3'd2, 4'b1000, 3'd0};
    tbl[5]  = '{6'b110000, 3'd2, 4'b0000, 3'd0};
    tbl[6]  = '{6'b110101, 3'd3, 4'b0010, 3'd0};
    tbl[7]  = '{6'b110100, 3'd3, 4'b0010, 3'd0};
    tbl[8]  = '{6'b111100, 3'd1, 4'b0100, 3'd0};
    tbl[9]  = '{6'b110000, 3'd2, 4'b1000, 3'd0};
    tbl[10] = '{6'b110001, 3'd5, 4'b0000, 3'd1};
    tbl[11] = '{6'b111000, 3'd1, 4'b0100, 3'd0};
    tbl[12] = '{6'b101000, 3'd0, 4'b0000, 3'd0};
    tbl[13] = '{6'b111010, 3'd1, 4'b0000, 3'd0};
    tbl[14] = '{6'b110000, 3'd2, 4'b1000, 3'd0};
    tbl[15] = '{6'b110100, 3'd3, 4'b0010, 3'd0};
    tbl[16] = '{6'b101100, 3'd0, 4'b0000, 3'd0};

    for (int i = 0; i < 17; i++) begin
      {rst, link_en, comreset_req, phy_ready, oob_busy, oob_error} = tbl[i].in;
      tick();
      chk($sformatf("vec%0d_state", i), 32'(state_out), 32'(tbl[i].st));
      chk($sformatf("vec%0d_flags", i), 32'({oob_start, comreset_ack, link_up, link_failed}),
          32'(tbl[i].flags));
      chk($sformatf("vec%0d_retry", i), 32'(retry_cnt), 32'(tbl[i].retry));
    end

    // Retry exhaustion with phy_ready held low.
    {rst, link_en, comreset_req, phy_ready, oob_busy, oob_error} = 6'b000000;
    tick();
    {rst, link_en} = 2'b11;
    for (int i = 0; i < 400 && state_out != 3'd6; i++) begin
      tick();
      if (oob_start) pulses.push_back(tick_n);
    end
    chk("retry_pulses", 32'(pulses.size()), 32'd3);
    // Pulse period covers the timeout window, the backoff and the START cycle.
    if (pulses.size() == 3) begin
      chk("retry_gap1", 32'(pulses[1] - pulses[0]), 32'(OOB_TO + BO + 1));
      chk("retry_gap2", 32'(pulses[2] - pulses[1]), 32'(OOB_TO + BO + 1));
    end
    chk("failed_state", 32'(state_out), 32'd6);
    chk("failed_flag", 32'(link_failed), 32'd1);
    chk("failed_retry", 32'(retry_cnt), 32'(MAXR));
    comreset_req = 1'b1;
    tick();
    comreset_req = 1'b0;
    chk("creq_ack", 32'(comreset_ack), 32'd1);
    chk("creq_state", 32'(state_out), 32'd1);
    chk("creq_retry", 32'(retry_cnt), 32'd0);
    chk("creq_failed", 32'(link_failed), 32'd0);

    // Debounce: 15-cycle glitch is filtered, 16-cycle drop is a loss.
    rst = 1'b0;
    tick();
    {rst, link_en, phy_ready, oob_busy} = 4'b1110;
    tick(); tick(); tick();
    chk("deb_linkup_state", 32'(state_out), 32'd3);
    phy_ready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!link_up) bad = 1'b1;
    end
    chk("deb15_up_held", 32'(bad), 32'd0);
    phy_ready = 1'b1;
    tick();
    chk("deb15_state", 32'(state_out), 32'd3);
    chk("deb15_loss", 32'(loss_cnt), 32'd0);
    phy_ready = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("deb16_state", 32'(state_out), 32'd1);
    chk("deb16_up", 32'(link_up), 32'd0);
    chk("deb16_loss", 32'(loss_cnt), 32'd1);
    tick();
    chk("deb16_restart", 32'(oob_start), 32'd1);

    // Reset in the middle of WAIT_OOB.
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    tick();
    chk("midrst_outputs", 32'({state_out, oob_start, comreset_ack, link_up, link_failed,
                              retry_cnt, loss_cnt}), 32'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("midrst_start", 32'(oob_start), 32'd1);
    chk("midrst_loss", 32'(loss_cnt), 32'd0);

    // oob_busy holds START with no pulse; pulse follows the release.
    rst = 1'b0;
    tick();
    {rst, link_en, phy_ready, oob_busy} = 4'b1101;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (oob_start || state_out != 3'd1) bad = 1'b1;
    end
    chk("busy_hold", 32'(bad), 32'd0);
    oob_busy = 1'b0;
    tick();
    chk("busy_release_pulse", 32'(oob_start), 32'd1);
    chk("busy_release_state", 32'(state_out), 32'd2);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 999) != 0);
      link_en      = ($urandom_range(0, 299) != 0);
      comreset_req = ($urandom_range(0, 99) < 2);
      oob_busy     = ($urandom_range(0, 99) < 30);
      oob_error    = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 4) phy_ready = ~phy_ready;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
